// File: rtl/div_pkg.sv
// Shared pipeline constants for the execute-stage divider: bus widths, FSM encoding, handshake levels.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic RstEnable         = 1'b1;

  // Magnitude of an operand; only signed operands with the MSB set are negated.
  function automatic logic [RegBus-1:0] op_abs(input logic is_signed, input logic [RegBus-1:0] v);
    return (is_signed && v[RegBus-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider: 33 cycles accept-to-ready (1 for divide-by-zero), registered outputs.
// The result is held while start_i stays high; dropping start_i or pulsing annul_i aborts or releases it.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_q;
  logic [5:0]              cnt_q;
  logic [DoubleRegBus:0]   work_q;
  logic [RegBus-1:0]       divisor_q;
  logic                    signed_q, sign1_q, sign2_q;
  logic [DoubleRegBus-1:0] result_q;
  logic                    ready_q;

  logic [RegBus:0]   diff_d;
  logic [RegBus-1:0] quot_d, rem_d;

  assign diff_d = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

  assign quot_d = (signed_q && (sign1_q ^ sign2_q)) ? (~work_q[31:0] + 1'b1) : work_q[31:0];
  assign rem_d  = (signed_q && sign1_q) ? (~work_q[64:33] + 1'b1) : work_q[64:33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            signed_q  <= signed_div_i;
            sign1_q   <= opdata1_i[RegBus-1];
            sign2_q   <= opdata2_i[RegBus-1];
            divisor_q <= op_abs(signed_div_i, opdata2_i);
            cnt_q     <= '0;
            work_q    <= {32'b0, op_abs(signed_div_i, opdata1_i), 1'b0};
            state_q   <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_q <= '0;
          ready_q  <= DivResultReady;
          state_q  <= DivEnd;
        end
        DivOn: begin
          if (annul_i || start_i == DivStop) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end else if (cnt_q != 6'd32) begin
            // Trial subtract: keep the shifted partial remainder when it underflows.
            if (diff_d[RegBus]) begin
              work_q <= work_q << 1;
            end else begin
              work_q <= {diff_d[31:0], work_q[31:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem_d, quot_d};
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus randomized operands against an arithmetic reference.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: divide magnitudes, then apply MIPS sign rules; x/0 yields 0/0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    logic        na, nb;
    if (b == 32'd0) return 64'd0;
    na = s && a[31];
    nb = s && b[31];
    ua = na ? (32'd0 - a) : a;
    ub = nb ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (na != nb) q = 32'd0 - q;
    if (na)       r = 32'd0 - r;
    return {r, q};
  endfunction

  // Launch one divide and hold start until ready; lat counts edges after the accept edge.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 100);
    res = result;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else n_pass++;
    n_checks++; if (result !== 64'd0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b0) $display("FAIL idle_ready got=%b exp=0", ready); else n_pass++;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res;
    do_op(1'b0, 32'd100, 32'd7, lat, res);
    n_checks++; if (lat !== 33) $display("FAIL u100_7_latency got=%0d exp=33", lat); else n_pass++;
    n_checks++; if (res !== {32'd2, 32'd14}) $display("FAIL u100_7_result got=%h exp=%h", res, {32'd2, 32'd14}); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1 || result !== {32'd2, 32'd14})
      $display("FAIL u100_7_hold got=%b/%h exp=1/%h", ready, result, {32'd2, 32'd14}); else n_pass++;
    release_start();
    n_checks++; if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL u100_7_release got=%b/%h exp=0/0", ready, result); else n_pass++;
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
    n_checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
      $display("FAIL s_m7_2 got=%h exp=%h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); else n_pass++;
    release_start();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    n_checks++; if (res !== {32'd0, 32'h8000_0000})
      $display("FAIL s_min_m1 got=%h exp=%h", res, {32'd0, 32'h8000_0000}); else n_pass++;
    release_start();
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    n_checks++; if (res !== {32'h8000_0000, 32'd0})
      $display("FAIL u_min_m1 got=%h exp=%h", res, {32'h8000_0000, 32'd0}); else n_pass++;
    release_start();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res;
    do_op(1'b0, 32'h1234, 32'd0, lat, res);
    n_checks++; if (lat !== 1) $display("FAIL dz_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (res !== 64'd0 || ready !== 1'b1)
      $display("FAIL dz_result got=%b/%h exp=1/0", ready, res); else n_pass++;
    release_start();
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; int seen;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul = 1'b1;
    @(negedge clk); annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || result !== 64'd0) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL annul_no_ready got=%0d exp=0 cycles with output", seen); else n_pass++;
    do_op(1'b0, 32'd9, 32'd3, lat, res);
    n_checks++; if (lat !== 33 || res !== {32'd0, 32'd3})
      $display("FAIL annul_then_9_3 got=%0d/%h exp=33/%h", lat, res, {32'd0, 32'd3}); else n_pass++;
    release_start();
  endtask

  task automatic test_async_reset();
    int lat; logic [63:0] res;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL arst_divon got=%b/%h exp=0/0", ready, result); else n_pass++;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    do_op(1'b0, 32'd1000, 32'd3, lat, res);
    n_checks++; if (ready !== 1'b1) $display("FAIL arst_pre_divend got=%b exp=1", ready); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL arst_divend got=%b/%h exp=0/0", ready, result); else n_pass++;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    do_op(1'b0, 32'd1000, 32'd3, lat, res);
    n_checks++; if (lat !== 33 || res !== {32'd1, 32'd333})
      $display("FAIL arst_recover got=%0d/%h exp=33/%h", lat, res, {32'd1, 32'd333}); else n_pass++;
    release_start();
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res;
    do_op(1'b1, 32'd77, 32'hFFFF_FFF6, lat, res);
    n_checks++; if (res !== ref_div(1'b1, 32'd77, 32'hFFFF_FFF6))
      $display("FAIL b2b_first got=%h exp=%h", res, ref_div(1'b1, 32'd77, 32'hFFFF_FFF6)); else n_pass++;
    release_start();
    do_op(1'b0, 32'hDEAD_BEEF, 32'd16, lat, res);
    n_checks++; if (lat !== 33 || res !== ref_div(1'b0, 32'hDEAD_BEEF, 32'd16))
      $display("FAIL b2b_second got=%0d/%h exp=33/%h", lat, res, ref_div(1'b0, 32'hDEAD_BEEF, 32'd16)); else n_pass++;
    release_start();
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [63:0] res, exp; logic s; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'd0;
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      exp     = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      do_op(s, a, b, lat, res);
      n_checks++; if (lat !== exp_lat || res !== exp)
        $display("FAIL rand%0d s=%b a=%h b=%h got=%0d/%h exp=%0d/%h", i, s, a, b, lat, res, exp_lat, exp);
      else n_pass++;
      release_start();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
